// File: rtl/dff_timing_monitor_if.sv
// rtl/dff_timing_monitor_if.sv - monitored lines and checker results for the DFF timing monitor
interface dff_timing_monitor_if #(
  parameter int CNT_W = 8
);
  logic             d_in;
  logic             mclk_in;
  logic             q_ref;
  logic             edge_pulse;
  logic             setup_viol;
  logic             hold_viol;
  logic [CNT_W-1:0] setup_cnt;
  logic [CNT_W-1:0] hold_cnt;

  // Side that drives the monitored data/clock lines and reads the verdicts
  modport master (
    output d_in,
    output mclk_in,
    input  q_ref,
    input  edge_pulse,
    input  setup_viol,
    input  hold_viol,
    input  setup_cnt,
    input  hold_cnt
  );

  // The monitor itself
  modport slave (
    input  d_in,
    input  mclk_in,
    output q_ref,
    output edge_pulse,
    output setup_viol,
    output hold_viol,
    output setup_cnt,
    output hold_cnt
  );
endinterface

// File: rtl/dff_timing_monitor.sv
// rtl/dff_timing_monitor.sv - oversampling setup/hold checker for a monitored flip-flop interface
module dff_timing_monitor #(
  parameter int SETUP_CYC = 5,
  parameter int HOLD_CYC  = 5,
  parameter int CNT_W     = 8
) (
  input logic                clk,
  input logic                rst,
  dff_timing_monitor_if.slave mon
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [7:0]       SETUP_THR = 8'(SETUP_CYC - 1);
  localparam logic [7:0]       HOLD_LD   = 8'(HOLD_CYC);
  localparam logic [7:0]       STABLE_MX = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Sampled lines and their one-cycle-old copies
  logic d_s, d_p, m_s, m_p;

  // Cycles since the last data change, and whether any change happened since reset
  logic [7:0] stable;
  logic       seen_change;

  // Hold-window tracker
  state_t     state;
  logic [7:0] win;

  // Per-cycle events derived from the sample pipeline
  logic edge_c, chg_c, setup_c, hold_c;

  // Event decode: a change that coincides with an edge belongs to setup, never hold
  always_comb begin
    edge_c  = m_s & ~m_p;
    chg_c   = d_s ^ d_p;
    setup_c = edge_c & seen_change & (chg_c | (stable < SETUP_THR));
    hold_c  = (state == HOLD) & chg_c & ~edge_c;
  end

  // Input stage: sample both monitored lines and keep the previous sample
  always_ff @(posedge clk) begin
    if (rst) begin
      d_s <= 1'b0;
      d_p <= 1'b0;
      m_s <= 1'b0;
      m_p <= 1'b0;
    end else begin
      d_s <= mon.d_in;
      d_p <= d_s;
      m_s <= mon.mclk_in;
      m_p <= m_s;
    end
  end

  // Stability counter: restarts on every data change, otherwise counts up and saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      stable      <= 8'd0;
      seen_change <= 1'b0;
    end else if (chg_c) begin
      stable      <= 8'd0;
      seen_change <= 1'b1;
    end else if (stable != STABLE_MX) begin
      stable      <= stable + 8'd1;
    end
  end

  // Hold-window FSM: each edge (re)opens a window of HOLD_CYC cycles after it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      win   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (edge_c) begin
            win   <= HOLD_LD;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (edge_c) begin
            win   <= HOLD_LD;
          end else if (win <= 8'd1) begin
            win   <= 8'd0;
            state <= IDLE;
          end else begin
            win   <= win - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          win   <= 8'd0;
        end
      endcase
    end
  end

  // Registered verdicts: pulses, reference capture and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      mon.q_ref      <= 1'b0;
      mon.edge_pulse <= 1'b0;
      mon.setup_viol <= 1'b0;
      mon.hold_viol  <= 1'b0;
      mon.setup_cnt  <= '0;
      mon.hold_cnt   <= '0;
    end else begin
      mon.edge_pulse <= edge_c;
      mon.setup_viol <= setup_c;
      mon.hold_viol  <= hold_c;
      // d_p is the value before any same-cycle change, i.e. what an ideal flop latches
      if (edge_c) begin
        mon.q_ref <= d_p;
      end
      if (setup_c && (mon.setup_cnt != CNT_MAX)) begin
        mon.setup_cnt <= mon.setup_cnt + CNT_ONE;
      end
      if (hold_c && (mon.hold_cnt != CNT_MAX)) begin
        mon.hold_cnt <= mon.hold_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_dff_timing_monitor.sv
// tb/tb_dff_timing_monitor.sv - self-checking bench for dff_timing_monitor
module tb_dff_timing_monitor;

  localparam int S = 5;
  localparam int H = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dff_timing_monitor_if #(.CNT_W(8)) bus ();
  dff_timing_monitor_if #(.CNT_W(2)) bus2 ();

  assign bus2.d_in    = bus.d_in;
  assign bus2.mclk_in = bus.mclk_in;

  dff_timing_monitor #(.SETUP_CYC(S), .HOLD_CYC(H), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus)
  );

  dff_timing_monitor #(.SETUP_CYC(S), .HOLD_CYC(H), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .mon (bus2)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: timestamps of the last change and last edge since reset
  int         n = 0;
  int         last_chg = -1;
  int         last_edge = -1;
  logic       cur_d = 1'b0, prev_d = 1'b0, cur_m = 1'b0, prev_m = 1'b0;
  logic       m_chg, m_edg;
  logic       e_q = 1'b0, e_edge = 1'b0, e_sv = 1'b0, e_hv = 1'b0;
  logic [7:0] e_sc = 8'd0, e_hc = 8'd0;
  logic [1:0] e_sc2 = 2'd0, e_hc2 = 2'd0;

  always @(posedge clk) begin
    if (rst) begin
      cur_d = 1'b0; prev_d = 1'b0; cur_m = 1'b0; prev_m = 1'b0;
      last_chg = -1; last_edge = -1;
      e_q = 1'b0; e_edge = 1'b0; e_sv = 1'b0; e_hv = 1'b0;
      e_sc = 8'd0; e_hc = 8'd0; e_sc2 = 2'd0; e_hc2 = 2'd0;
    end else begin
      m_chg  = (cur_d != prev_d);
      m_edg  = cur_m && !prev_m;
      e_sv   = m_edg && (last_chg >= 0) && (m_chg || (n - last_chg < S));
      e_hv   = m_chg && !m_edg && (last_edge >= 0) && (n - last_edge <= H);
      e_edge = m_edg;
      if (m_edg) e_q = prev_d;
      if (e_sv && e_sc != 8'd255) e_sc = e_sc + 8'd1;
      if (e_hv && e_hc != 8'd255) e_hc = e_hc + 8'd1;
      if (e_sv && e_sc2 != 2'd3) e_sc2 = e_sc2 + 2'd1;
      if (e_hv && e_hc2 != 2'd3) e_hc2 = e_hc2 + 2'd1;
      if (m_chg) last_chg = n;
      if (m_edg) last_edge = n;
      prev_d = cur_d; cur_d = bus.d_in;
      prev_m = cur_m; cur_m = bus.mclk_in;
    end
    n = n + 1;
  end

  logic [23:0] obs_v, exp_v;
  assign obs_v = {bus.q_ref, bus.edge_pulse, bus.setup_viol, bus.hold_viol,
                  bus.setup_cnt, bus.hold_cnt, bus2.setup_cnt, bus2.hold_cnt};
  assign exp_v = {e_q, e_edge, e_sv, e_hv, e_sc, e_hc, e_sc2, e_hc2};

  typedef struct packed {
    logic r;
    logic d;
    logic m;
  } stim_t;
  stim_t sq[$];

  task automatic push(input int cnt, input logic r, input logic d, input logic m);
    for (int i = 0; i < cnt; i++) sq.push_back({r, d, m});
  endtask

  task automatic step(input stim_t s);
    rst = s.r;
    bus.d_in = s.d;
    bus.mclk_in = s.m;
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t s;
    push(4, 1'b1, 1'b1, 1'b1);
    push(3, 1'b1, 1'b0, 1'b1);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      total++;
      if (obs_v !== 24'h0) begin
        bad++; $display("FAIL reset_state got=%h want=000000", obs_v);
      end
    end
    push(10, 1'b0, 1'b0, 1'b0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL reset_release got=%h want=%h", obs_v, exp_v);
      end
    end
  endtask

  task automatic test_clean();
    stim_t s;
    int ne = 0, ns = 0, nh = 0;
    push(100, 1'b0, 1'b0, 1'b0);
    push(100, 1'b0, 1'b0, 1'b1);
    push(80,  1'b0, 1'b0, 1'b0);
    push(20,  1'b0, 1'b1, 1'b0);
    push(100, 1'b0, 1'b1, 1'b1);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL clean_cycle got=%h want=%h", obs_v, exp_v);
      end
      ne += int'(bus.edge_pulse); ns += int'(bus.setup_viol); nh += int'(bus.hold_viol);
    end
    total++; if (ne !== 2) begin bad++; $display("FAIL clean_edge_pulses got=%0d want=2", ne); end
    total++; if (ns + nh !== 0) begin bad++; $display("FAIL clean_viol got=%0d want=0", ns + nh); end
    total++; if (bus.q_ref !== 1'b1) begin bad++; $display("FAIL clean_q_ref got=%b want=1", bus.q_ref); end
  endtask

  task automatic test_setup();
    stim_t s;
    int ns = 0;
    push(99,  1'b0, 1'b1, 1'b0);
    push(1,   1'b0, 1'b0, 1'b0);
    push(100, 1'b0, 1'b0, 1'b1);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL setup_cycle got=%h want=%h", obs_v, exp_v);
      end
      ns += int'(bus.setup_viol);
    end
    total++; if (ns !== 1) begin bad++; $display("FAIL setup_pulses got=%0d want=1", ns); end
    total++; if (bus.setup_cnt !== 8'd1) begin bad++; $display("FAIL setup_cnt got=%0d want=1", bus.setup_cnt); end
    total++; if (bus.hold_cnt !== 8'd0) begin bad++; $display("FAIL setup_hold_cnt got=%0d want=0", bus.hold_cnt); end
    total++; if (bus.q_ref !== 1'b0) begin bad++; $display("FAIL setup_q_ref got=%b want=0", bus.q_ref); end
  endtask

  task automatic test_hold();
    stim_t s;
    int nh = 0;
    push(100, 1'b0, 1'b0, 1'b0);
    push(20,  1'b0, 1'b0, 1'b1);
    push(80,  1'b0, 1'b1, 1'b1);
    push(100, 1'b0, 1'b1, 1'b0);
    push(1,   1'b0, 1'b1, 1'b1);
    push(99,  1'b0, 1'b0, 1'b1);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL hold_cycle got=%h want=%h", obs_v, exp_v);
      end
      nh += int'(bus.hold_viol);
    end
    total++; if (nh !== 1) begin bad++; $display("FAIL hold_pulses got=%0d want=1", nh); end
    total++; if (bus.hold_cnt !== 8'd1) begin bad++; $display("FAIL hold_cnt got=%0d want=1", bus.hold_cnt); end
    total++; if (bus.setup_cnt !== 8'd1) begin bad++; $display("FAIL hold_setup_cnt got=%0d want=1", bus.setup_cnt); end
  endtask

  task automatic test_same_cycle();
    stim_t s;
    int ns = 0, nh = 0;
    push(100, 1'b0, 1'b0, 1'b0);
    push(100, 1'b0, 1'b1, 1'b1);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL same_cycle got=%h want=%h", obs_v, exp_v);
      end
      ns += int'(bus.setup_viol); nh += int'(bus.hold_viol);
    end
    total++; if (ns !== 1 || nh !== 0) begin bad++; $display("FAIL same_pulses got=%0d/%0d want=1/0", ns, nh); end
    total++; if (bus.setup_cnt !== 8'd2) begin bad++; $display("FAIL same_setup_cnt got=%0d want=2", bus.setup_cnt); end
    total++; if (bus.q_ref !== 1'b0) begin bad++; $display("FAIL same_q_ref got=%b want=0", bus.q_ref); end
  endtask

  task automatic test_saturate();
    stim_t s;
    int ns = 0;
    logic d = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(60, 1'b0, d, 1'b0);
      d = ~d;
      push(1,  1'b0, d, 1'b0);
      push(40, 1'b0, d, 1'b1);
    end
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL sat_cycle got=%h want=%h", obs_v, exp_v);
      end
      ns += int'(bus2.setup_viol);
    end
    total++; if (ns !== 5) begin bad++; $display("FAIL sat_pulses got=%0d want=5", ns); end
    total++; if (bus2.setup_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt2 got=%0d want=3", bus2.setup_cnt); end
    total++; if (bus.setup_cnt !== 8'd7) begin bad++; $display("FAIL sat_cnt8 got=%0d want=7", bus.setup_cnt); end
    total++; if (bus2.hold_cnt !== 2'd1) begin bad++; $display("FAIL sat_hold2 got=%0d want=1", bus2.hold_cnt); end
  endtask

  task automatic test_reset_mid();
    stim_t s;
    int ns = 0, nh = 0, ne = 0;
    push(50, 1'b0, 1'b0, 1'b0);
    push(2,  1'b0, 1'b0, 1'b1);
    push(1,  1'b1, 1'b0, 1'b0);
    push(3,  1'b0, 1'b1, 1'b0);
    push(20, 1'b0, 1'b1, 1'b0);
    push(20, 1'b0, 1'b0, 1'b0);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL rstmid_cycle got=%h want=%h", obs_v, exp_v);
      end
      if (s.r) begin
        total++;
        if (obs_v !== 24'h0) begin bad++; $display("FAIL rstmid_zero got=%h want=000000", obs_v); end
      end
      nh += int'(bus.hold_viol); ns += int'(bus.setup_viol);
    end
    total++; if (nh !== 0 || ns !== 0) begin bad++; $display("FAIL rstmid_pulses got=%0d/%0d want=0/0", ns, nh); end
    total++; if (bus.setup_cnt !== 8'd0 || bus.hold_cnt !== 8'd0) begin
      bad++; $display("FAIL rstmid_cnts got=%0d/%0d want=0/0", bus.setup_cnt, bus.hold_cnt);
    end
    ns = 0;
    push(1,  1'b1, 1'b0, 1'b0);
    push(2,  1'b0, 1'b0, 1'b0);
    push(30, 1'b0, 1'b0, 1'b1);
    push(40, 1'b0, 1'b0, 1'b0);
    push(1,  1'b0, 1'b1, 1'b0);
    push(10, 1'b0, 1'b1, 1'b1);
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL rstmid2_cycle got=%h want=%h", obs_v, exp_v);
      end
      ns += int'(bus.setup_viol); ne += int'(bus.edge_pulse);
    end
    total++; if (ns !== 1 || ne !== 2) begin bad++; $display("FAIL rstmid2_pulses got=%0d/%0d want=1/2", ns, ne); end
    total++; if (bus.setup_cnt !== 8'd1) begin bad++; $display("FAIL rstmid2_cnt got=%0d want=1", bus.setup_cnt); end
  endtask

  task automatic test_random();
    stim_t s;
    int cyc = 0;
    logic d = 1'b0, m = 1'b0;
    while (cyc < 4000) begin
      int len;
      if ($urandom_range(0, 60) == 0) begin
        push(1, 1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        cyc += 1;
      end
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 1) == 1) d = ~d;
      if ($urandom_range(0, 2) == 0) m = ~m;
      push(len, 1'b0, d, m);
      cyc += len;
    end
    while (sq.size() > 0) begin
      s = sq.pop_front();
      step(s);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL random_cycle got=%h want=%h t=%0t", obs_v, exp_v, $time);
      end
    end
  endtask

  initial begin
    bus.d_in = 1'b0;
    bus.mclk_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_clean();
    test_setup();
    test_hold();
    test_same_cycle();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
